// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into 64-bit word
// accesses, with read-modify-write for narrow stores and extension for loads.
module load_store_unit #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [63:0]       mem_w_data,
    input  logic [63:0]       mem_r_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic              resp_fault,
    output logic [1:0]        resp_cause
);

    localparam int unsigned MEM_WORDS = ROM_WORDS + RAM_WORDS;
    localparam int unsigned HI_LSB    = ADDR_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        off_q, off_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]       mem_w_data_q, mem_w_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_data_q, resp_data_d;
    logic              resp_fault_q, resp_fault_d;
    logic [1:0]        resp_cause_q, resp_cause_d;

    logic [ADDR_W-1:0] req_widx;
    logic              addr_hi_nz;
    logic [1:0]        req_cause;
    logic [5:0]        lane_sh;
    logic [63:0]       rd_sh;
    logic [63:0]       load_ext;
    logic [63:0]       lane_mask;
    logic [63:0]       merge_val;

    assign req_widx   = req_addr[ADDR_W+2:3];
    assign addr_hi_nz = |(req_addr >> HI_LSB);

    // Fault classification of the incoming request, highest priority first.
    always_comb begin
        req_cause = 2'b00;
        if ((!req_store && req_funct3 == 3'b111) || (req_store && req_funct3[2])) begin
            req_cause = 2'b11;
        end else if ((req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'd2 && |req_addr[1:0]) ||
                     (req_funct3[1:0] == 2'd3 && |req_addr[2:0])) begin
            req_cause = 2'b01;
        end else if (addr_hi_nz || (32'(req_widx) >= MEM_WORDS) ||
                     (req_store && 32'(req_widx) < ROM_WORDS)) begin
            req_cause = 2'b10;
        end
    end

    // Byte-lane selection and extension of the read word for loads.
    assign lane_sh = {off_q, 3'b000};
    assign rd_sh   = mem_r_data >> lane_sh;

    always_comb begin
        load_ext = 64'd0;
        case (funct3_q)
            3'b000:  load_ext = {{56{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  load_ext = {{48{rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  load_ext = {{32{rd_sh[31]}}, rd_sh[31:0]};
            3'b011:  load_ext = rd_sh;
            3'b100:  load_ext = {56'd0, rd_sh[7:0]};
            3'b101:  load_ext = {48'd0, rd_sh[15:0]};
            3'b110:  load_ext = {32'd0, rd_sh[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    // Narrow-store merge into the word just read.
    always_comb begin
        lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (funct3_q[1:0])
            2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        merge_val = (mem_r_data & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
    end

    // Next-state and next-output logic; outputs are decoded from the next state.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        widx_d       = widx_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        resp_cause_d = resp_cause_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d        = req_addr[2:0];
                    widx_d       = req_widx;
                    funct3_d     = req_funct3;
                    wdata_d      = req_wdata;
                    resp_data_d  = 64'd0;
                    resp_fault_d = (req_cause != 2'b00);
                    resp_cause_d = req_cause;
                    if (req_cause != 2'b00)        state_d = S_RESP;
                    else if (!req_store)           state_d = S_LOAD;
                    else if (req_funct3[1:0] == 2'd3) state_d = S_WRITE;
                    else                           state_d = S_MERGE;
                end
            end
            S_LOAD: begin
                resp_data_d = load_ext;
                state_d     = S_RESP;
            end
            S_MERGE: state_d = S_WRITE;
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        mem_re_d     = (state_d == S_LOAD) || (state_d == S_MERGE);
        mem_we_d     = (state_d == S_WRITE);
        mem_addr_d   = (mem_re_d || mem_we_d) ? widx_d : '0;
        mem_w_data_d = 64'd0;
        if (state_d == S_WRITE) begin
            mem_w_data_d = (state_q == S_MERGE) ? merge_val : wdata_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            off_q        <= 3'd0;
            widx_q       <= '0;
            funct3_q     <= 3'd0;
            wdata_q      <= 64'd0;
            req_ready_q  <= 1'b1;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_data_q <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 64'd0;
            resp_fault_q <= 1'b0;
            resp_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            widx_q       <= widx_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
            resp_cause_q <= resp_cause_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;
    assign resp_cause = resp_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset-during-write sequence and
// random traffic against a byte-array reference model of the memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [8:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_w_data;
    logic [63:0] mem_r_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_fault;
    logic [1:0]  resp_cause;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_fault(resp_fault), .resp_cause(resp_cause)
    );

    // ROM contents are a fixed function of the word index.
    function automatic logic [63:0] rom_word(input int unsigned i);
        return {i * 32'h9E37_79B9, i ^ 32'hA5A5_0F0F};
    endfunction

    // Memory model: ROM words 0..255, RAM words 256..511.
    logic [63:0] ram [256];
    logic        rom_wr_seen;
    assign mem_r_data = mem_addr[8] ? ram[mem_addr[7:0]] : rom_word(32'(mem_addr));

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 64'd0;
        rom_wr_seen = 1'b0;
        forever begin
            @(posedge clk);
            if (mem_we) begin
                if (mem_addr[8]) ram[mem_addr[7:0]] <= mem_w_data;
                else             rom_wr_seen <= 1'b1;
            end
        end
    end

    // Reference model state: the whole 4 KiB address space as bytes.
    logic [7:0] ref_mem [4096];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int unsigned widx);
        logic [63:0] w = 64'd0;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_mem[widx*8 + b];
        return w;
    endfunction

    // Expected outcome of a request, from the architectural rules.
    task automatic model_eval(input logic st, input logic [2:0] f3, input logic [63:0] a,
                              output logic flt, output logic [1:0] cause,
                              output logic [63:0] data, output int lat);
        int unsigned size = 1 << f3[1:0];
        logic [63:0] v = 64'd0;
        if ((!st && f3 == 3'd7) || (st && f3[2]))  cause = 2'd3;
        else if ((a % 64'(size)) != 64'd0)          cause = 2'd1;
        else if (a >= 64'd4096 || (st && a < 64'd2048)) cause = 2'd2;
        else                                        cause = 2'd0;
        flt  = (cause != 2'd0);
        data = 64'd0;
        if (!flt && !st) begin
            for (int unsigned i = 0; i < size; i++) v = v | (64'(ref_mem[32'(a) + i]) << (8*i));
            if (!f3[2] && size < 8 && ((v >> (8*size - 1)) & 64'd1) == 64'd1)
                v = v | (~64'd0 << (8*size));
            data = v;
        end
        lat = flt ? 1 : (!st ? 2 : (size == 8 ? 2 : 3));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " req_ready"},  64'(req_ready), 64'd1);
        chk({nm, " mem_re"},     64'(mem_re), 64'd0);
        chk({nm, " mem_we"},     64'(mem_we), 64'd0);
        chk({nm, " mem_addr"},   64'(mem_addr), 64'd0);
        chk({nm, " mem_w_data"}, mem_w_data, 64'd0);
        chk({nm, " resp_valid"}, 64'(resp_valid), 64'd0);
        chk({nm, " resp_data"},  resp_data, 64'd0);
        chk({nm, " resp_fault"}, 64'(resp_fault), 64'd0);
        chk({nm, " resp_cause"}, 64'(resp_cause), 64'd0);
    endtask

    // One full transaction; starts and ends just after a falling edge.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int hold,
                          input logic e_flt, input logic [1:0] e_cause,
                          input logic [63:0] e_data, input int e_lat, input string nm);
        logic        e_re, e_we, seen;
        logic [63:0] e_word, held;
        int          re_n, we_n, k;
        e_re   = !e_flt && (!st || f3[1:0] != 2'd3);
        e_we   = !e_flt && st;
        e_word = 64'd0;
        if (e_we) begin
            for (int unsigned i = 0; i < (1 << f3[1:0]); i++) ref_mem[32'(a) + i] = wd[8*i +: 8];
            e_word = ref_word(32'(a >> 3));
        end
        chk({nm, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        k = 1; seen = 1'b0; re_n = 0; we_n = 0;
        while (!seen && k <= 10) begin
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                if (mem_re) re_n++;
                if (mem_we) begin
                    we_n++;
                    chk({nm, " w_data"}, mem_w_data, e_word);
                end
                if (mem_re || mem_we) chk({nm, " mem_addr"}, 64'(mem_addr), a >> 3);
                chk({nm, " req_ready busy"}, 64'(req_ready), 64'd0);
                k++;
                @(negedge clk);
            end
        end
        chk({nm, " resp seen"}, 64'(seen), 64'd1);
        chk({nm, " latency"}, 64'(k), 64'(e_lat));
        chk({nm, " re cycles"}, 64'(re_n), 64'(e_re));
        chk({nm, " we cycles"}, 64'(we_n), 64'(e_we));
        chk({nm, " fault"}, 64'(resp_fault), 64'(e_flt));
        chk({nm, " cause"}, 64'(resp_cause), 64'(e_cause));
        chk({nm, " data"}, resp_data, e_data);
        held = resp_data;
        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                @(negedge clk);
                chk({nm, " held valid"}, 64'(resp_valid), 64'd1);
                chk({nm, " held data"}, resp_data, held);
                chk({nm, " held ready"}, 64'(req_ready), 64'd0);
                chk({nm, " held strobes"}, 64'(mem_re | mem_we), 64'd0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk({nm, " ready after"}, 64'(req_ready), 64'd1);
        chk({nm, " valid after"}, 64'(resp_valid), 64'd0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          hold;
        logic        flt;
        logic [1:0]  cause;
        logic [63:0] data;
        int          lat;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic        r_st, r_flt;
        logic [2:0]  r_f3;
        logic [63:0] r_a, r_wd, r_data;
        logic [1:0]  r_cause;
        int          r_lat;

        tbl[0]  = '{1'b1, 3'd3, 64'h800, 64'h1122334455667788, 0, 1'b0, 2'd0, 64'd0, 2};
        tbl[1]  = '{1'b0, 3'd0, 64'h807, 64'd0, 0, 1'b0, 2'd0, 64'h0000000000000011, 2};
        tbl[2]  = '{1'b0, 3'd0, 64'h800, 64'd0, 0, 1'b0, 2'd0, 64'hFFFFFFFFFFFFFF88, 2};
        tbl[3]  = '{1'b0, 3'd5, 64'h806, 64'd0, 0, 1'b0, 2'd0, 64'h0000000000001122, 2};
        tbl[4]  = '{1'b1, 3'd0, 64'h801, 64'hAB, 0, 1'b0, 2'd0, 64'd0, 3};
        tbl[5]  = '{1'b0, 3'd3, 64'h800, 64'd0, 0, 1'b0, 2'd0, 64'h112233445566AB88, 2};
        tbl[6]  = '{1'b1, 3'd2, 64'h804, 64'hCAFEF00D, 0, 1'b0, 2'd0, 64'd0, 3};
        tbl[7]  = '{1'b0, 3'd6, 64'h804, 64'd0, 0, 1'b0, 2'd0, 64'h00000000CAFEF00D, 2};
        tbl[8]  = '{1'b0, 3'd2, 64'h804, 64'd0, 0, 1'b0, 2'd0, 64'hFFFFFFFFCAFEF00D, 2};
        tbl[9]  = '{1'b1, 3'd1, 64'h80A, 64'h1234BEEF, 0, 1'b0, 2'd0, 64'd0, 3};
        tbl[10] = '{1'b0, 3'd1, 64'h80A, 64'd0, 0, 1'b0, 2'd0, 64'hFFFFFFFFFFFFBEEF, 2};
        tbl[11] = '{1'b0, 3'd3, 64'h808, 64'd0, 3, 1'b0, 2'd0, 64'h00000000BEEF0000, 2};
        tbl[12] = '{1'b0, 3'd2, 64'h802, 64'd0, 0, 1'b1, 2'd1, 64'd0, 1};
        tbl[13] = '{1'b0, 3'd7, 64'h803, 64'd0, 0, 1'b1, 2'd3, 64'd0, 1};
        tbl[14] = '{1'b1, 3'd2, 64'h008, 64'h55, 0, 1'b1, 2'd2, 64'd0, 1};
        tbl[15] = '{1'b0, 3'd3, 64'h1000, 64'd0, 0, 1'b1, 2'd2, 64'd0, 1};
        tbl[16] = '{1'b1, 3'd4, 64'h800, 64'h77, 2, 1'b1, 2'd3, 64'd0, 1};
        tbl[17] = '{1'b1, 3'd1, 64'h801, 64'h77, 0, 1'b1, 2'd1, 64'd0, 1};
        tbl[18] = '{1'b0, 3'd4, 64'h801, 64'd0, 0, 1'b0, 2'd0, 64'h00000000000000AB, 2};
        tbl[19] = '{1'b1, 3'd3, 64'hFF8, 64'h0123456789ABCDEF, 0, 1'b0, 2'd0, 64'd0, 2};
        tbl[20] = '{1'b0, 3'd3, 64'hFF8, 64'd0, 0, 1'b0, 2'd0, 64'h0123456789ABCDEF, 2};
        tbl[21] = '{1'b1, 3'd0, 64'h7FF, 64'h12, 0, 1'b1, 2'd2, 64'd0, 1};

        for (int w = 0; w < 512; w++)
            for (int b = 0; b < 8; b++)
                ref_mem[w*8 + b] = (w < 256) ? rom_word(32'(w)) >> (8*b) : 8'd0;

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b1;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 22; i++)
            do_txn(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                   tbl[i].flt, tbl[i].cause, tbl[i].data, tbl[i].lat, $sformatf("tbl%0d", i));

        // Reset while a merged SW is in its write cycle: nothing may be committed.
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 64'h810; req_wdata = 64'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstw merge re", 64'(mem_re), 64'd1);
        @(negedge clk);
        chk("rstw write we", 64'(mem_we), 64'd1);
        chk("rstw write data", mem_w_data, 64'h00000000DEADBEEF);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rstw async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstw no resp", 64'(resp_valid), 64'd0);
        end
        do_txn(1'b0, 3'd3, 64'h810, 64'd0, 0, 1'b0, 2'd0, 64'd0, 2, "rstw reload");

        for (int n = 0; n < 300; n++) begin
            r_st = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = 64'($urandom_range(0, 4095));
            if (r_st && $urandom_range(0, 3) != 0) r_a = 64'd2048 + 64'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) r_a = r_a & ~64'((1 << r_f3[1:0]) - 1);
            if ($urandom_range(0, 9) == 0) r_a = r_a | (64'd1 << $urandom_range(12, 63));
            r_wd = {$urandom, $urandom};
            model_eval(r_st, r_f3, r_a, r_flt, r_cause, r_data, r_lat);
            do_txn(r_st, r_f3, r_a, r_wd, $urandom_range(0, 2), r_flt, r_cause, r_data, r_lat,
                   $sformatf("rnd%0d", n));
        end

        for (int i = 0; i < 256; i++) chk($sformatf("ram word %0d", i), ram[i], ref_word(32'(256 + i)));
        chk("rom untouched", 64'(rom_wr_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and `data_memory`. It accepts one load or store request per transaction with a byte address, size and signedness, and converts it into 64-bit word accesses on the 9-bit word-addressed data memory. Sub-doubleword stores are done as a read-modify-write; loads are zero- or sign-extended. The block reports misaligned, illegal and out-of-range accesses as faults without touching memory, and returns a result over a valid/ready response handshake.

## Interface

Parameters:
- `ROM_WORDS`, default 256: number of read-only words at word indices 0..ROM_WORDS-1.
- `RAM_WORDS`, default 256: number of writable words at word indices ROM_WORDS..ROM_WORDS+RAM_WORDS-1.
- `ADDR_W`, default 9: width of the memory word address.

Ports (reset rst, asynchronous, active-high; clock clk):
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high exactly when the FSM is in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 encoding.
  - Loads: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - Stores: SB=000, SH=001, SW=010, SD=011.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data; the low bytes are used.
- `mem_addr` out ADDR_W: word address, equal to the latched `byte_addr[ADDR_W+2:3]`.
- `mem_re` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `mem_w_data` out 64: full word to write.
- `mem_r_data` in 64: combinational read data from memory.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 64: extended load result; 0 for stores and faults.
- `resp_fault` out 1: the access faulted.
- `resp_cause` out 2: fault cause. 00 = none, 01 = misaligned, 10 = access, 11 = illegal funct3.

## Operation

- **Handshake and latching.** A request is accepted on a clk edge with `req_valid && req_ready`. On acceptance the block latches store, funct3, addr and wdata. Nothing downstream depends combinationally on the `req_*` inputs.
- **Fault checks.** These are evaluated at acceptance, in priority order:
  1. Illegal funct3: a load with 111, or a store with funct3[2]=1, gives cause 11.
  2. Misaligned: H with addr[0]≠0, W with addr[1:0]≠0, or D with addr[2:0]≠0 gives cause 01.
  3. Access fault gives cause 10 when any of the following holds:
     - addr[63:ADDR_W+3]≠0;
     - word index ≥ ROM_WORDS+RAM_WORDS;
     - the request is a store and word index < ROM_WORDS.
- **Faulted requests.** A faulted request goes directly to RESP. `mem_re` and `mem_we` are never asserted for it.
- **FSM states:**
  - IDLE:
    - fault → RESP.
    - load → LOAD.
    - SD → WRITE, with merged = wdata.
    - SB/SH/SW → MERGE.
  - LOAD: `mem_re`=1. Select the byte lane at addr[2:0] from `mem_r_data`, extend it per funct3 and register it into `resp_data`. Then → RESP.
  - MERGE: `mem_re`=1. Register merged = `mem_r_data` with bytes [addr[2:0] .. addr[2:0]+size-1] replaced by wdata[size*8-1:0]. Then → WRITE.
  - WRITE: `mem_we`=1, `mem_w_data`=merged. Then → RESP.
  - RESP: `resp_valid`=1. Stay until `resp_ready`=1, then → IDLE.
- **Output drive.** `mem_re`, `mem_we` and `mem_addr` are decoded from the state register and latched fields only. `mem_w_data` is 0 outside WRITE. `mem_addr` is 0 in IDLE and RESP.
- **Response stability.** `resp_data`, `resp_fault` and `resp_cause` are stable for the whole time RESP is held.

## Timing

- **Latency.** With acceptance at edge N and `resp_ready` already high:
  - fault: `resp_valid` from N+1;
  - load and SD: `resp_valid` from N+2;
  - SB/SH/SW: `resp_valid` from N+3.
- **Throughput.** One transaction is in flight at a time. `req_ready`=0 from the edge after acceptance until the cycle after the response handshake completes. The minimum issue interval is therefore 3 cycles for a load.
- **Backpressure.** `resp_ready` low holds RESP indefinitely. No memory strobes are issued while held.
- **Reset values.** These apply immediately on rst:
  - state = IDLE;
  - `req_ready`=1;
  - `mem_re`, `mem_we` = 0;
  - `mem_addr`, `mem_w_data`, `resp_data` = 0;
  - `resp_valid`, `resp_fault` = 0;
  - `resp_cause` = 00.
- **Reset mid-operation.** Reset aborts any transaction. A WRITE in progress drops `mem_we` asynchronously, so no partial or merged write is committed after rst rises. No response is produced for the aborted request.
- **Read timing.** A memory read is sampled at the end of the cycle in which `mem_re` is high, using combinational `mem_r_data`. A write commits on the clk edge ending the WRITE cycle.

## Test plan

- **SD then extended loads.** All responses have fault 0.
  - SD to 0x800 with data 0x1122334455667788: `mem_we`=1 with `mem_addr`=256 in cycle N+1, `resp_valid` at N+2.
  - LB 0x807 returns 0x0000000000000011.
  - LB 0x800 returns 0xFFFFFFFFFFFFFF88.
  - LHU 0x806 returns 0x0000000000001122.
- **RMW store.** After the SD above, SB to 0x801 with data 0xAB: `mem_re` at N+1, `mem_we` at N+2 with `mem_w_data`=0x112233445566AB88, resp at N+3. A following LD 0x800 returns 0x112233445566AB88.
- **Fault priority and cause codes.** No memory strobe is seen for any of these, and each responds at N+1.
  - LW 0x802 gives cause 01.
  - Load with funct3 111 at 0x803 gives cause 11.
  - SW to 0x008 gives cause 10.
  - LD 0x1000 gives cause 10.
- **Backpressure.** For a load at 0x808, hold `resp_ready` low for 3 cycles. `resp_valid` and `resp_data` stay constant, `req_ready` stays 0, and there are no strobes. The transfer completes on the first cycle `resp_ready`=1, and `req_ready` is 1 on the next cycle.
- **Reset during WRITE.** Assert rst during the WRITE cycle of SW 0x810 with data 0xDEADBEEF. `mem_we` falls immediately, all outputs take their reset values, and a later LD 0x810 returns its prior value of 0.
